systolic_feeder: RTL and testbench

- Edge driver for the N×N systolic multiply array built from PE tiles.
- Holds operand matrix A (row-major, N×N) and matrix B (N×N), loaded through a simple write port.
- On a go request it streams A rows into the west edge and B columns into the north edge with the diagonal skew the array needs, then drains and signals done.
- Sits between the host/load logic and the array; it is the transmitter for the PE in_a/in_b/in_valid/start inputs.

---
 rtl/systolic_feeder_if.sv | 31 +++
 rtl/systolic_feeder.sv | 145 ++++++++++++++
 tb/tb_systolic_feeder.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/systolic_feeder_if.sv
// Host-side load/go port and array edge bus of the systolic feeder.
interface systolic_feeder_if #(
    parameter int N  = 4,
    parameter int DW = 8
);
    localparam int IW = $clog2(N);

    logic            wr_en;
    logic            wr_sel;
    logic [IW-1:0]   wr_row;
    logic [IW-1:0]   wr_col;
    logic [DW-1:0]   wr_data;
    logic            go;
    logic            busy;
    logic            done;
    logic            arr_start;
    logic [N*DW-1:0] a_out;
    logic [N-1:0]    a_valid;
    logic [N*DW-1:0] b_out;
    logic [N-1:0]    b_valid;

    modport master (
        output wr_en, wr_sel, wr_row, wr_col, wr_data, go,
        input  busy, done, arr_start, a_out, a_valid, b_out, b_valid
    );

    modport slave (
        input  wr_en, wr_sel, wr_row, wr_col, wr_data, go,
        output busy, done, arr_start, a_out, a_valid, b_out, b_valid
    );
endinterface

// File: rtl/systolic_feeder.sv
// Holds operand matrices A and B and streams them, diagonally skewed, into
// the west and north edges of an NxN systolic array.
module systolic_feeder #(
    parameter int N  = 4,
    parameter int DW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    systolic_feeder_if.slave  bus
);
    localparam int IW = $clog2(N);
    localparam int SW = $clog2(2*N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   step_q, step_d;

    logic [DW-1:0]   a_mem_q [N][N];
    logic [DW-1:0]   a_mem_d [N][N];
    logic [DW-1:0]   b_mem_q [N][N];
    logic [DW-1:0]   b_mem_d [N][N];

    logic [N*DW-1:0] a_out_q, a_out_d;
    logic [N*DW-1:0] b_out_q, b_out_d;
    logic [N-1:0]    a_valid_q, a_valid_d;
    logic [N-1:0]    b_valid_q, b_valid_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
        end
    end

    // step_q is the feed step t in FEED and the drain cycle index in DRAIN.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        case (state_q)
            S_IDLE: begin
                if (bus.go) begin
                    state_d = S_FEED;
                    step_d  = '0;
                end
            end
            S_FEED: begin
                if (step_q == SW'(2*N - 2)) begin
                    state_d = S_DRAIN;
                    step_d  = '0;
                end else begin
                    step_d = step_q + SW'(1);
                end
            end
            S_DRAIN: begin
                if (step_q == SW'(N - 1)) begin
                    state_d = S_DONE;
                    step_d  = '0;
                end else begin
                    step_d = step_q + SW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                step_d  = '0;
            end
            default: begin
                state_d = S_IDLE;
                step_d  = '0;
            end
        endcase
    end

    always_comb begin
        a_mem_d = a_mem_q;
        b_mem_d = b_mem_q;
        if (state_q == S_IDLE && bus.wr_en &&
            int'(bus.wr_row) < N && int'(bus.wr_col) < N) begin
            if (!bus.wr_sel) begin
                a_mem_d[bus.wr_row][bus.wr_col] = bus.wr_data;
            end else begin
                b_mem_d[bus.wr_row][bus.wr_col] = bus.wr_data;
            end
        end
    end

    // Edge registers are computed from next state/storage so a write landing
    // on the go edge is already visible at F0.
    always_comb begin
        int k;
        a_out_d   = '0;
        b_out_d   = '0;
        a_valid_d = '0;
        b_valid_d = '0;
        k         = 0;
        if (state_d == S_FEED) begin
            for (int i = 0; i < N; i++) begin
                k = int'(step_d) - i;
                if (k >= 0 && k < N) begin
                    a_valid_d[i]        = 1'b1;
                    b_valid_d[i]        = 1'b1;
                    a_out_d[i*DW +: DW] = a_mem_d[IW'(i)][IW'(k)];
                    b_out_d[i*DW +: DW] = b_mem_d[IW'(k)][IW'(i)];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_mem_q   <= '{default: '0};
            b_mem_q   <= '{default: '0};
            a_out_q   <= '0;
            b_out_q   <= '0;
            a_valid_q <= '0;
            b_valid_q <= '0;
        end else begin
            a_mem_q   <= a_mem_d;
            b_mem_q   <= b_mem_d;
            a_out_q   <= a_out_d;
            b_out_q   <= b_out_d;
            a_valid_q <= a_valid_d;
            b_valid_q <= b_valid_d;
        end
    end

    always_comb begin
        bus.busy      = (state_q != S_IDLE);
        bus.done      = (state_q == S_DONE);
        bus.arr_start = (state_q == S_FEED) || (state_q == S_DRAIN);
    end

    assign bus.a_out   = a_out_q;
    assign bus.b_out   = b_out_q;
    assign bus.a_valid = a_valid_q;
    assign bus.b_valid = b_valid_q;
endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder with a cycle-level reference model.
module tb_systolic_feeder;
    localparam int N  = 4;
    localparam int DW = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    systolic_feeder_if #(.N(N), .DW(DW)) bus ();

    systolic_feeder #(.N(N), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [DW-1:0] m_a [N][N];
    logic [DW-1:0] m_b [N][N];
    int            m_cnt  = -1;
    bit            chk_en = 1'b0;
    int            n_err  = 0;
    int            n_chk  = 0;

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic setIdle();
        bus.wr_en   = 1'b0;
        bus.wr_sel  = 1'b0;
        bus.wr_row  = '0;
        bus.wr_col  = '0;
        bus.wr_data = '0;
        bus.go      = 1'b0;
    endtask

    task automatic applyStimulus(input logic we, input logic sel, input int row,
                                 input int col, input int data, input logic g);
        @(negedge clk);
        bus.wr_en   = we;
        bus.wr_sel  = sel;
        bus.wr_row  = 2'(row);
        bus.wr_col  = 2'(col);
        bus.wr_data = 8'(data);
        bus.go      = g;
    endtask

    // Busy cycle c counts from 0 at F0; F0..F(2N-2) feed, then N drain, then done.
    task automatic waitFrame(input int f);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (m_cnt != f && n < 200);
        if (m_cnt != f) begin
            n_chk++;
            n_err++;
            $display("[TB] FAIL wait_frame: got frame %0d expected %0d", m_cnt, f);
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    m_a[i][j] = '0;
                    m_b[i][j] = '0;
                end
            m_cnt = -1;
        end else if (m_cnt < 0) begin
            if (bus.wr_en) begin
                if (!bus.wr_sel) m_a[bus.wr_row][bus.wr_col] = bus.wr_data;
                else             m_b[bus.wr_row][bus.wr_col] = bus.wr_data;
            end
            if (bus.go) m_cnt = 0;
        end else if (m_cnt == 3*N - 1) begin
            m_cnt = -1;
        end else begin
            m_cnt++;
        end
    end

    logic [N*DW-1:0] e_a, e_b;
    logic [N-1:0]    e_va, e_vb;

    always @(negedge clk) begin
        if (chk_en) begin
            e_a  = '0;
            e_b  = '0;
            e_va = '0;
            e_vb = '0;
            if (m_cnt >= 0 && m_cnt <= 2*N - 2) begin
                for (int i = 0; i < N; i++) begin
                    int k;
                    k = m_cnt - i;
                    if (k >= 0 && k < N) begin
                        e_va[i]          = 1'b1;
                        e_vb[i]          = 1'b1;
                        e_a[i*DW +: DW]  = m_a[i][k];
                        e_b[i*DW +: DW]  = m_b[k][i];
                    end
                end
            end
            checkOutput("busy",      32'(bus.busy),      32'(m_cnt >= 0));
            checkOutput("done",      32'(bus.done),      32'(m_cnt == 3*N - 1));
            checkOutput("arr_start", 32'(bus.arr_start), 32'(m_cnt >= 0 && m_cnt <= 3*N - 2));
            checkOutput("a_valid",   32'(bus.a_valid),   32'(e_va));
            checkOutput("b_valid",   32'(bus.b_valid),   32'(e_vb));
            checkOutput("a_out",     bus.a_out,          e_a);
            checkOutput("b_out",     bus.b_out,          e_b);
        end
    end

    initial begin
        setIdle();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        checkOutput("rst busy",  32'(bus.busy), 32'd0);
        checkOutput("rst a_out", bus.a_out,     32'd0);
        checkOutput("rst b_val", 32'(bus.b_valid), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++)
                applyStimulus(1'b1, 1'b0, i, k, 10*i + k + 1, 1'b0);
        for (int k = 0; k < N; k++)
            for (int j = 0; j < N; j++)
                applyStimulus(1'b1, 1'b1, k, j, 10*k + j + 101, 1'b0);

        $display("[TB] skew and timing run");
        applyStimulus(1'b0, 1'b0, 0, 0, 0, 1'b1);
        waitFrame(0);
        setIdle();
        checkOutput("F0 a_out",   bus.a_out,   {8'd0, 8'd0, 8'd0, 8'd1});
        checkOutput("F0 b_out",   bus.b_out,   {8'd0, 8'd0, 8'd0, 8'd101});
        checkOutput("F0 a_valid", 32'(bus.a_valid), 32'h1);
        waitFrame(1);
        checkOutput("F1 a_out",   bus.a_out,   {8'd0, 8'd0, 8'd11, 8'd2});
        checkOutput("F1 b_out",   bus.b_out,   {8'd0, 8'd0, 8'd102, 8'd111});
        waitFrame(2);
        bus.wr_en   = 1'b1;
        bus.wr_sel  = 1'b0;
        bus.wr_row  = '0;
        bus.wr_col  = '0;
        bus.wr_data = 8'hFF;
        bus.go      = 1'b1;
        waitFrame(3);
        setIdle();
        checkOutput("F3 a_out",   bus.a_out,   {8'd31, 8'd22, 8'd13, 8'd4});
        checkOutput("F3 b_out",   bus.b_out,   {8'd104, 8'd113, 8'd122, 8'd131});
        checkOutput("F3 b_valid", 32'(bus.b_valid), 32'hF);
        waitFrame(6);
        checkOutput("F6 a_out",   bus.a_out,   {8'd34, 8'd0, 8'd0, 8'd0});
        checkOutput("F6 b_out",   bus.b_out,   {8'd134, 8'd0, 8'd0, 8'd0});
        checkOutput("F6 a_valid", 32'(bus.a_valid), 32'h8);
        waitFrame(10);
        checkOutput("F10 arr_start", 32'(bus.arr_start), 32'd1);
        waitFrame(11);
        checkOutput("F11 done",      32'(bus.done),      32'd1);
        checkOutput("F11 arr_start", 32'(bus.arr_start), 32'd0);
        @(negedge clk);
        checkOutput("F12 busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        checkOutput("no restart busy", 32'(bus.busy), 32'd0);

        $display("[TB] replay run");
        applyStimulus(1'b0, 1'b0, 0, 0, 0, 1'b1);
        waitFrame(0);
        setIdle();
        checkOutput("replay F0 row0", 32'(bus.a_out[7:0]), 32'd1);
        waitFrame(11);
        @(negedge clk);

        $display("[TB] same-cycle write and go");
        applyStimulus(1'b1, 1'b0, 2, 1, 8'h5A, 1'b1);
        waitFrame(0);
        setIdle();
        waitFrame(3);
        checkOutput("wr+go F3 row2", 32'(bus.a_out[23:16]), 32'h5A);
        waitFrame(11);
        @(negedge clk);

        $display("[TB] abort run");
        applyStimulus(1'b0, 1'b0, 0, 0, 0, 1'b1);
        waitFrame(0);
        setIdle();
        waitFrame(4);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("abort busy",    32'(bus.busy),    32'd0);
        checkOutput("abort a_valid", 32'(bus.a_valid), 32'd0);
        checkOutput("abort done",    32'(bus.done),    32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 0, 0, 0, 1'b1);
        waitFrame(0);
        setIdle();
        waitFrame(3);
        checkOutput("zeros F3 a_valid", 32'(bus.a_valid), 32'hF);
        checkOutput("zeros F3 a_out",   bus.a_out,        32'd0);
        checkOutput("zeros F3 b_out",   bus.b_out,        32'd0);
        waitFrame(11);
        checkOutput("zeros F11 done", 32'(bus.done), 32'd1);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
